cmult_fixed_pipe: RTL and testbench

CMULT_FIXED_PIPE -- requirements
Module: cmult_fixed_pipe

---
 rtl/cmult_fixed_pipe.sv | 72 +++++++
 tb/tb_cmult_fixed_pipe.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmult_fixed_pipe.sv
// cmult_fixed_pipe: three-stage pipelined fixed-point complex multiplier
// with ready/valid flow control, rounding, saturation and sticky overflow.
module cmult_fixed_pipe #(
    parameter int W     = 32,
    parameter int FRAC  = 16,
    parameter int ROUND = 0,
    parameter int SAT   = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] a_re,
    input  logic [W-1:0] a_im,
    input  logic [W-1:0] b_re,
    input  logic [W-1:0] b_im,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] c_re,
    output logic [W-1:0] c_im,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         ovf,
    output logic         ovf_sticky,
    input  logic         ovf_clr
);
    localparam logic signed [2*W+1:0] half = (2*W+2)'(ROUND != 0) << (FRAC - 1);

    logic en, v1, v2;
    logic signed [2*W-1:0] p_rr, p_ii, p_ri, p_ir;
    logic signed [2*W:0] s_re, s_im;
    logic [W:0] q_re, q_im;

    // Returns {overflow, W-bit result}; one guard bit keeps the rounding add exact.
    function automatic logic [W:0] scale(input logic signed [2*W:0] x);
        logic signed [2*W+1:0] t;
        logic of;
        t = ($signed({x[2*W], x}) + half) >>> FRAC;
        of = !(&t[2*W+1:W-1] || !(|t[2*W+1:W-1]));
        return {of, (of && SAT != 0) ? {t[2*W+1], {(W-1){~t[2*W+1]}}} : t[W-1:0]};
    endfunction

    assign en = !out_valid || out_ready;
    assign in_ready = en;
    assign q_re = scale(s_re);
    assign q_im = scale(s_im);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            {v1, v2, out_valid, ovf, ovf_sticky} <= '0;
            {p_rr, p_ii, p_ri, p_ir, s_re, s_im, c_re, c_im} <= '0;
        end else begin
            if (en) begin
                v1        <= in_valid;
                p_rr      <= (2*W)'($signed(a_re)) * (2*W)'($signed(b_re));
                p_ii      <= (2*W)'($signed(a_im)) * (2*W)'($signed(b_im));
                p_ri      <= (2*W)'($signed(a_re)) * (2*W)'($signed(b_im));
                p_ir      <= (2*W)'($signed(a_im)) * (2*W)'($signed(b_re));
                v2        <= v1;
                s_re      <= (2*W+1)'(p_rr) - (2*W+1)'(p_ii);
                s_im      <= (2*W+1)'(p_ri) + (2*W+1)'(p_ir);
                out_valid <= v2;
                c_re      <= q_re[W-1:0];
                c_im      <= q_im[W-1:0];
                ovf       <= q_re[W] | q_im[W];
            end
            // A flagged transfer beats a simultaneous clear.
            if (out_valid && out_ready && ovf)
                ovf_sticky <= 1'b1;
            else if (ovf_clr)
                ovf_sticky <= 1'b0;
        end
    end
endmodule

// File: tb/tb_cmult_fixed_pipe.sv
// tb_cmult_fixed_pipe: drives three parameter variants (trunc/sat, round/sat, trunc/wrap)
// with shared stimulus and checks them against a wide-integer reference model.
module tb_cmult_fixed_pipe;
    localparam int W = 32;
    localparam int FRAC = 16;
    typedef struct { logic [W-1:0] ar, ai, br, bi; } smp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [W-1:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0;
    logic in_valid = 1'b0, out_ready = 1'b1, ovf_clr = 1'b0;
    logic in_ready [3];
    logic [W-1:0] c_re [3];
    logic [W-1:0] c_im [3];
    logic out_valid [3];
    logic ovf [3];
    logic ovf_sticky [3];
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    for (genvar i = 0; i < 3; i++) begin : g_dut
        cmult_fixed_pipe #(.W(W), .FRAC(FRAC), .ROUND(i == 1 ? 1 : 0), .SAT(i == 2 ? 0 : 1)) dut (
            .clk(clk), .rst(rst),
            .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
            .in_valid(in_valid), .in_ready(in_ready[i]),
            .c_re(c_re[i]), .c_im(c_im[i]),
            .out_valid(out_valid[i]), .out_ready(out_ready),
            .ovf(ovf[i]), .ovf_sticky(ovf_sticky[i]), .ovf_clr(ovf_clr)
        );
    end

    // Variant k: 0 = truncate/saturate, 1 = round/saturate, 2 = truncate/wrap. Returns {ovf, re, im}.
    function automatic logic [2*W:0] model(input smp_t s, input int k);
        logic signed [127:0] xr, xi, yr, yi, lo, hi;
        logic signed [127:0] v [2];
        logic [W-1:0] r [2];
        logic of;
        xr = $signed(s.ar); xi = $signed(s.ai); yr = $signed(s.br); yi = $signed(s.bi);
        lo = -(128'sd1 <<< (W - 1));
        hi = (128'sd1 <<< (W - 1)) - 1;
        v[0] = xr * yr - xi * yi;
        v[1] = xr * yi + xi * yr;
        of = 1'b0;
        for (int j = 0; j < 2; j++) begin
            if (k == 1) v[j] = v[j] + (128'sd1 <<< (FRAC - 1));
            v[j] = v[j] >>> FRAC;
            if (v[j] > hi || v[j] < lo) begin
                of = 1'b1;
                if (k != 2) v[j] = (v[j] > hi) ? hi : lo;
            end
            r[j] = v[j][W-1:0];
        end
        return {of, r[0], r[1]};
    endfunction

    function automatic logic [W-1:0] rnd_val();
        logic signed [W-1:0] v;
        v = $signed($urandom);
        if ($urandom_range(0, 7) == 0) return {1'b1, {(W-1){1'b0}}};
        v = v >>> $urandom_range(0, 24);
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sends one sample and returns the number of edges from accept until out_valid (accept edge = 1).
    task automatic run_one(input logic [W-1:0] ar, ai, br, bi, input logic rdy, output int lat);
        a_re = ar; a_im = ai; b_re = br; b_im = bi;
        in_valid = 1'b1;
        out_ready = rdy;
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid[0] && lat < 20) begin
            step();
            lat++;
        end
    endtask

    task automatic run_stream(input int n, input bit hs_rand, input int stall_lo, input int stall_hi);
        smp_t q[$];
        smp_t s, h;
        int sent = 0, got = 0, cyc = 0;
        logic [W-1:0] held = '0;
        bit stalled_prev = 1'b0;
        logic [2*W:0] exp;
        while (got < n && cyc < 400) begin
            s = '{rnd_val(), rnd_val(), rnd_val(), rnd_val()};
            a_re = s.ar; a_im = s.ai; b_re = s.br; b_im = s.bi;
            in_valid = (sent < n) && (!hs_rand || $urandom_range(0, 3) != 0);
            out_ready = hs_rand ? ($urandom_range(0, 2) != 0) : !(cyc >= stall_lo && cyc < stall_hi);
            @(negedge clk);
            if (!out_ready && out_valid[0]) begin
                total++;
                if (in_ready[0] !== 1'b0) begin
                    bad++;
                    $display("FAIL stall_in_ready cyc=%0d: got %b want 0", cyc, in_ready[0]);
                end
                if (stalled_prev) begin
                    total++;
                    if (c_re[0] !== held) begin
                        bad++;
                        $display("FAIL stall_hold cyc=%0d: c_re got %h want %h", cyc, c_re[0], held);
                    end
                end
                held = c_re[0];
                stalled_prev = 1'b1;
            end else stalled_prev = 1'b0;
            if (out_valid[0] && out_ready) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL stream_extra cyc=%0d: got unexpected output c=(%h,%h) want none", cyc, c_re[0], c_im[0]);
                end else begin
                    h = q.pop_front();
                    for (int i = 0; i < 3; i++) begin
                        exp = model(h, i);
                        total++;
                        if ({ovf[i], c_re[i], c_im[i]} !== exp) begin
                            bad++;
                            $display("FAIL stream dut%0d sample%0d: got ovf=%b c=(%h,%h) want ovf=%b c=(%h,%h)",
                                     i, got, ovf[i], c_re[i], c_im[i], exp[2*W], exp[2*W-1:W], exp[W-1:0]);
                        end
                    end
                end
                got++;
            end
            if (in_valid && in_ready[0]) begin
                q.push_back(s);
                sent++;
            end
            step();
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        total++;
        if (got != n || q.size() != 0) begin
            bad++;
            $display("FAIL stream_count: got %0d outputs (%0d pending) want %0d", got, q.size(), n);
        end
        repeat (4) step();
    endtask

    task automatic test_reset();
        #1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({out_valid[i], ovf[i], ovf_sticky[i], in_ready[i], c_re[i], c_im[i]} !== {4'b0001, {(2*W){1'b0}}}) begin
                bad++;
                $display("FAIL reset dut%0d: got v=%b ovf=%b st=%b rdy=%b c=(%h,%h) want v=0 ovf=0 st=0 rdy=1 c=0",
                         i, out_valid[i], ovf[i], ovf_sticky[i], in_ready[i], c_re[i], c_im[i]);
            end
        end
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic test_basic();
        int lat;
        run_one(32'h00010000, 32'h0, 32'h00008000, 32'h00010000, 1'b1, lat);
        total++;
        if (lat != 3) begin
            bad++;
            $display("FAIL basic_latency: got %0d want 3", lat);
        end
        total++;
        if ({ovf[0], c_re[0], c_im[0]} !== {1'b0, 32'h00008000, 32'h00010000}) begin
            bad++;
            $display("FAIL basic_value: got ovf=%b c=(%h,%h) want ovf=0 c=(00008000,00010000)", ovf[0], c_re[0], c_im[0]);
        end
        step();
    endtask

    task automatic test_round();
        int lat;
        run_one(32'h00000001, 32'h0, 32'h00008000, 32'h0, 1'b1, lat);
        total++;
        if ({c_re[0], c_re[1]} !== {32'h0, 32'h1}) begin
            bad++;
            $display("FAIL round_pos: got trunc=%h round=%h want trunc=00000000 round=00000001", c_re[0], c_re[1]);
        end
        step();
        run_one(32'hFFFFFFFF, 32'h0, 32'h00008000, 32'h0, 1'b1, lat);
        total++;
        if ({c_re[0], c_re[1]} !== {32'hFFFFFFFF, 32'h0}) begin
            bad++;
            $display("FAIL round_neg: got trunc=%h round=%h want trunc=ffffffff round=00000000", c_re[0], c_re[1]);
        end
        step();
    endtask

    task automatic test_sat();
        int lat;
        run_one(32'h80000000, 32'h0, 32'h80000000, 32'h0, 1'b1, lat);
        total++;
        if ({ovf[0], c_re[0], c_im[0]} !== {1'b1, 32'h7FFFFFFF, 32'h0}) begin
            bad++;
            $display("FAIL sat_clamp: got ovf=%b c=(%h,%h) want ovf=1 c=(7fffffff,00000000)", ovf[0], c_re[0], c_im[0]);
        end
        total++;
        if ({ovf[2], c_re[2]} !== {1'b1, 32'h0}) begin
            bad++;
            $display("FAIL sat_wrap: got ovf=%b c_re=%h want ovf=1 c_re=00000000", ovf[2], c_re[2]);
        end
        step();
        total++;
        if (ovf_sticky[0] !== 1'b1) begin
            bad++;
            $display("FAIL sat_sticky: got %b want 1", ovf_sticky[0]);
        end
    endtask

    task automatic test_clear_collision();
        int lat;
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        total++;
        if (ovf_sticky[0] !== 1'b0) begin
            bad++;
            $display("FAIL clr_alone_first: got %b want 0", ovf_sticky[0]);
        end
        run_one(32'h80000000, 32'h0, 32'h80000000, 32'h0, 1'b0, lat);
        step();
        total++;
        if ({out_valid[0], ovf[0], ovf_sticky[0]} !== 3'b110) begin
            bad++;
            $display("FAIL sticky_needs_transfer: got v=%b ovf=%b st=%b want v=1 ovf=1 st=0", out_valid[0], ovf[0], ovf_sticky[0]);
        end
        out_ready = 1'b1;
        ovf_clr = 1'b1;
        step();
        total++;
        if (ovf_sticky[0] !== 1'b1) begin
            bad++;
            $display("FAIL set_beats_clear: got %b want 1", ovf_sticky[0]);
        end
        step();
        ovf_clr = 1'b0;
        total++;
        if (ovf_sticky[0] !== 1'b0) begin
            bad++;
            $display("FAIL clr_alone_later: got %b want 0", ovf_sticky[0]);
        end
    endtask

    task automatic test_back_to_back();
        run_stream(8, 1'b0, 4, 9);
    endtask

    task automatic test_random();
        run_stream(40, 1'b1, 0, 0);
    endtask

    task automatic test_reset_midstream();
        int lat;
        bit stale = 1'b0;
        smp_t s;
        logic [2*W:0] exp;
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            a_re = rnd_val(); a_im = rnd_val(); b_re = rnd_val(); b_im = rnd_val();
            step();
        end
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        total++;
        if ({out_valid[0], ovf[0], ovf_sticky[0], c_re[0], c_im[0]} !== '0) begin
            bad++;
            $display("FAIL reset_mid: got v=%b ovf=%b st=%b c=(%h,%h) want all 0", out_valid[0], ovf[0], ovf_sticky[0], c_re[0], c_im[0]);
        end
        step();
        rst = 1'b1;
        repeat (5) begin
            step();
            if (out_valid[0]) stale = 1'b1;
        end
        total++;
        if (stale) begin
            bad++;
            $display("FAIL reset_stale: got out_valid=1 after release want 0");
        end
        s = '{rnd_val(), rnd_val(), rnd_val(), rnd_val()};
        run_one(s.ar, s.ai, s.br, s.bi, 1'b1, lat);
        total++;
        if (lat != 3) begin
            bad++;
            $display("FAIL reset_latency: got %0d want 3", lat);
        end
        exp = model(s, 0);
        total++;
        if ({ovf[0], c_re[0], c_im[0]} !== exp) begin
            bad++;
            $display("FAIL reset_value: got ovf=%b c=(%h,%h) want ovf=%b c=(%h,%h)",
                     ovf[0], c_re[0], c_im[0], exp[2*W], exp[2*W-1:W], exp[W-1:0]);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round();
        test_sat();
        test_clear_collision();
        test_back_to_back();
        test_random();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
